// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux_scan block: mode encoding, state type and
// the width helper used for select and dwell-counter widths.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    typedef enum logic {
        ST_MANUAL = MODE_MANUAL,
        ST_AUTO   = MODE_AUTO
    } state_t;

    // Bits needed to index n values, never less than 1.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Dwell counter and round-robin index generator for the auto-scan mode.
// Raises advance on the last dwell cycle and offers the wrapped next index.
module scan_counter
    import mux_scan_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int DWELL = 4,
    localparam int SELW  = clog2_safe(NCH),
    localparam int CW    = clog2_safe(DWELL + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            clear,
    input  logic [SELW-1:0] cur,
    output logic            advance,
    output logic [SELW-1:0] next_idx
);

    logic [CW-1:0] count;

    assign advance  = !clear && (count == CW'(DWELL - 1));
    assign next_idx = (cur == SELW'(NCH - 1)) ? '0 : cur + SELW'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (enable) begin
            if (clear || advance) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual select and round-robin
// auto scan; every output is a register.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    parameter  int DWELL = 4,
    localparam int SELW  = clog2_safe(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] din,
    output logic [WIDTH-1:0]     dout,
    output logic [SELW-1:0]      cur_sel,
    output logic                 switch_pulse,
    output logic                 valid
);

    state_t          state_q, state_d;
    logic            clear, advance;
    logic [SELW-1:0] next_idx, next_sel;
    logic [WIDTH-1:0] ch [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign ch[k] = din[k*WIDTH +: WIDTH];
    end

    // Counter is held at zero in manual mode and on the edge entering auto,
    // so a fresh scan always dwells a full DWELL cycles on cur_sel.
    assign clear = (mode == MODE_MANUAL) || (state_q == ST_MANUAL);

    scan_counter #(
        .NCH   (NCH),
        .DWELL (DWELL)
    ) u_scan_counter (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clear    (clear),
        .cur      (cur_sel),
        .advance  (advance),
        .next_idx (next_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_MANUAL;
        else     state_q <= state_d;
    end

    // NOTE: defaults are assigned first so no path through the block leaves
    // a signal unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        next_sel = cur_sel;
        if (enable) begin
            state_d = (mode == MODE_AUTO) ? ST_AUTO : ST_MANUAL;
        end
        if (mode == MODE_MANUAL) begin
            // Out-of-range requests (non-power-of-2 NCH) are ignored.
            if ({1'b0, sel} < (SELW + 1)'(NCH)) next_sel = sel;
        end else if (advance) begin
            next_sel = next_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout         <= '0;
            cur_sel      <= '0;
            switch_pulse <= 1'b0;
            valid        <= 1'b0;
        end else if (enable) begin
            cur_sel      <= next_sel;
            dout         <= ch[next_sel];
            switch_pulse <= (next_sel != cur_sel);
            valid        <= 1'b1;
        end else begin
            switch_pulse <= 1'b0;
        end
    end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised, registered N-channel, W-bit multiplexer.
- Generalises the 2:1 select to NCH channels of WIDTH bits each.
- Adds two modes: manual select and automatic round-robin scan with a programmable dwell time.
- Used to time-share one downstream datapath, such as a display or LED bank, across several sources.

Parameters:
WIDTH, 8, bit width of each channel and of dout
NCH, 4, number of input channels (legal range 2 to 16)
DWELL, 4, cycles spent on each channel in auto mode (legal range 1 to 65535)

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  1 = block advances and samples; 0 = all state frozen
mode  in  1  0 = manual (MANUAL), 1 = auto scan (AUTO)
sel  in  SELW  manual channel index; SELW = max(1, clog2(NCH))
din  in  NCH*WIDTH  packed inputs; channel k is din[k*WIDTH +: WIDTH]
dout  out  WIDTH  registered selected channel data
cur_sel  out  SELW  index of the channel currently driving dout
switch_pulse  out  1  one-cycle strobe; high in the cycle after cur_sel changed
valid  out  1  high once dout has been loaded at least once since reset

Behaviour:
- Reset: on a rising edge with rst=1, the following clear to 0:
  - dout, cur_sel, switch_pulse, valid
  - dwell counter, mode state (MANUAL)
- rst has priority over enable and mode.
- States: MANUAL, AUTO.
  - State register follows the mode input on every enabled edge.
  - Transition MANUAL->AUTO: dwell counter cleared to 0; scan continues from the current cur_sel (no jump to 0).
  - Transition AUTO->MANUAL: next_sel = sel, taken on that same edge.
- next_sel computation, evaluated every edge with enable=1:
  - MANUAL with sel < NCH: next_sel = sel.
  - MANUAL with sel >= NCH (only possible for non-power-of-2 NCH): next_sel = cur_sel. Out-of-range requests are ignored and never wrap.
  - AUTO with count == DWELL-1: next_sel = (cur_sel == NCH-1) ? 0 : cur_sel+1, and count <= 0.
  - AUTO otherwise: next_sel = cur_sel, and count <= count+1.
- Register update on each enabled edge:
  - cur_sel <= next_sel
  - dout <= channel next_sel of din, sampled at this edge
  - switch_pulse <= (next_sel != cur_sel)
  - valid <= 1
- Latency: din to dout is exactly 1 cycle. The sel change is visible on cur_sel and dout after the same edge.
- DWELL=1: channel advances every enabled cycle; the count stays at 0.
- enable=0:
  - dout, cur_sel, count and state hold.
  - switch_pulse is forced to 0.
  - valid holds.
  - A held DWELL count resumes where it stopped.
- Dwell counter width is clog2(DWELL+1). It never exceeds DWELL-1.
- No combinational path from any input to any output; all outputs are registers.
- Reset asserted mid-scan: state returns to channel 0 and count 0 on the next edge. No pulse is generated for that edge.

Decomposition:
- Shared package mux_scan_pkg holds:
  - mode encoding constants MODE_MANUAL=1'b0 and MODE_AUTO=1'b1
  - a clog2-safe width helper function used for SELW and the counter width
- One sub-module is natural: scan_counter, the dwell counter plus round-robin index generator.
  - Inputs: clk, rst, enable, clear.
  - Outputs: advance strobe and next index.
  - The top level contains the select mux, mode state and output registers.

Test Plan:
1. Reset and valid: WIDTH=8, NCH=4, din={8'h44,8'h33,8'h22,8'h11}. Hold rst=1 for 2 cycles, then release with enable=1, mode=0, sel=0.
   - While rst=1: dout=0, valid=0.
   - One cycle after release: dout=8'h11, valid=1, cur_sel=0.
2. Manual select: from case 1, step sel 0->2->3->3.
   - dout=8'h33 then 8'h44 then 8'h44, each one cycle after the sel change.
   - switch_pulse=1,1,0.
   - With NCH=3, WIDTH=8, sel=3: cur_sel holds its previous value and no pulse.
3. Auto scan with wrap: DWELL=3, mode=1 held for 14 cycles.
   - cur_sel sequence: 0,0,0,1,1,1,2,2,2,3,3,3,0,0.
   - switch_pulse high exactly on the cycles where cur_sel first shows 1, 2, 3 and 0.
4. Enable freeze: in auto mode at count=1 on channel 2, drop enable for 5 cycles, then raise it.
   - dout and cur_sel unchanged during the freeze; no pulses.
   - Channel 3 is reached exactly 2 enabled cycles after enable returns.
5. Mode switching:
   - Auto on channel 1 -> mode=0 with sel=3: cur_sel=3 next cycle, pulse=1.
   - Then mode=1: stays on 3 for DWELL cycles, then goes to 0.
6. Reset mid-operation and DWELL=1:
   - With DWELL=1, auto mode: cur_sel increments every cycle.
   - rst pulsed for 1 cycle while on channel 2: cur_sel=0, dout=0, valid=0, switch_pulse=0.
   - Scan resumes from 0 after rst is released.
